// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the data-memory responder: FSM state encoding,
//   word size in bytes, byte-counter width and the address range helper.
//   Imported by dmem_responder and its testbench.
// ----------------------------------------------------------------------------
package dmem_responder_pkg;

  // Responder FSM states (encodings are fixed so debug traces stay stable).
  typedef enum logic [1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_ACCESS = 2'd1,
    DMEM_RESP   = 2'd2
  } dmem_state_e;

  // Bytes per 64-bit request.
  localparam int DMEM_WORD_BYTES = 8;

  // Byte counter runs 0..DMEM_WORD_BYTES: eight byte cycles plus one drain
  // cycle for the registered RAM read.
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_WORD_BYTES);

  // True when an 8-byte access starting at addr would run past the RAM.
  // Compared on the full 64 bits against the last legal start address, so no
  // addition is involved and addresses near 2^64 cannot wrap into range.
  function automatic logic addr_out_of_range(input logic [63:0] addr,
                                             input logic [63:0] last_ok);
    return (addr > last_ok);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bus between the memory-access stage (master) and the
//   data-memory responder (slave). Signal names carry the responder's
//   direction suffix (_i into the responder, _o out of it).
//
//   Handshake rules (both channels): a transfer happens on a rising clock
//   edge where valid and ready are both 1. Once valid is raised the payload
//   is held stable until that transfer. Request and response never overlap:
//   req_ready_o is 1 only while the responder is idle, and rsp_ready_i is
//   only looked at while rsp_valid_o is 1.
//
//   Request : req_valid_i, req_ready_o, req_we_i, req_addr_i, req_wdata_i
//   Response: rsp_valid_o, rsp_ready_i, rsp_rdata_o, rsp_error_o
// ----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_error_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// ----------------------------------------------------------------------------
// dmem_byte_ram
//   Single-port, byte-wide synchronous RAM. Write-first is not needed by the
//   responder (it never reads and writes the same cycle), so the read is a
//   plain registered read of the addressed location. Contents are not reset.
//
//   Ports:
//     clk_i    clock
//     we_i     write enable for addr_i
//     addr_i   byte index [ADDR_W-1:0]
//     wdata_i  write byte
//     rdata_o  registered read byte (one cycle after addr_i)
//   The storage array is named mem for backdoor access.
// ----------------------------------------------------------------------------
module dmem_byte_ram #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Serves one 64-bit read or write per request against a byte-wide
//   synchronous RAM, one byte per cycle, little-endian (byte k of the word
//   lives at addr+k). Out-of-range requests skip the RAM and respond with
//   rsp_error_o=1 one cycle after the accept edge; in-range requests respond
//   ten cycles after the accept edge (accept + 9 ACCESS cycles).
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_n_i      asynchronous active-low reset
//     bus          dmem_responder_if.slave request/response channels
//     dbg_state_o  current FSM state
//     dbg_cnt_o    current byte counter
//
//   Build option: define DMEM_ALIGN_CHECK_EN to also reject addresses with
//   req_addr_i[2:0] != 0 through the one-cycle error path.
// ----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  dmem_responder_if.slave  bus,
  output dmem_state_e      dbg_state_o,
  output logic [CNT_W-1:0] dbg_cnt_o
);

  // Last start address whose 8 bytes all fit in the RAM.
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - DMEM_WORD_BYTES);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              error_q, error_d;

  logic              req_bad;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic [2:0]        fill_idx;

  // --------------------------------------------------------------------------
  // Request screening
  // --------------------------------------------------------------------------
  always_comb begin
    req_bad = addr_out_of_range(bus.req_addr_i, LAST_OK);
`ifdef DMEM_ALIGN_CHECK_EN
    req_bad = req_bad | (bus.req_addr_i[2:0] != 3'd0);
`endif
  end

  // The byte returned by the RAM this cycle was addressed in the previous
  // cycle, so it belongs to slot cnt-1 (cnt=8 wraps to slot 7: the drain).
  assign fill_idx = cnt_q[2:0] - 3'd1;

  // --------------------------------------------------------------------------
  // Next-state and RAM control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    ram_we    = 1'b0;
    ram_addr  = addr_q + ADDR_W'(cnt_q[2:0]);
    ram_wdata = wdata_q[{cnt_q[2:0], 3'b000} +: 8];

    unique case (state_q)
      DMEM_IDLE: begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i[ADDR_W-1:0];
          we_d    = bus.req_we_i;
          wdata_d = bus.req_wdata_i;
          rdata_d = '0;
          cnt_d   = '0;
          error_d = req_bad;
          state_d = req_bad ? DMEM_RESP : DMEM_ACCESS;
        end
      end

      DMEM_ACCESS: begin
        // Cycles 0..7 issue bytes; cycle 8 only collects the last read byte.
        ram_we = we_q && (cnt_q != CNT_LAST);
        if (!we_q && (cnt_q != '0)) begin
          rdata_d[{fill_idx, 3'b000} +: 8] = ram_rdata;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DMEM_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DMEM_RESP: begin
        if (bus.rsp_ready_i) begin
          state_d = DMEM_IDLE;
        end
      end

      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // --------------------------------------------------------------------------
  // RAM
  // --------------------------------------------------------------------------
  dmem_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Outputs. Data and error are gated by RESP so they read 0 at all other
  // times, including straight after an asynchronous reset.
  // --------------------------------------------------------------------------
  assign bus.req_ready_o = (state_q == DMEM_IDLE);
  assign bus.rsp_valid_o = (state_q == DMEM_RESP);
  assign bus.rsp_rdata_o = (state_q == DMEM_RESP) ? rdata_q : 64'd0;
  assign bus.rsp_error_o = (state_q == DMEM_RESP) ? error_q : 1'b0;

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the memory-access stage's request interface.
- Accepts one 64-bit read or write request per handshake and serves it against a byte-wide synchronous RAM, one byte per cycle, in little-endian order.
- Returns the read data or write acknowledge through a valid/ready response channel, with an error flag for out-of-range addresses.
- Replaces the zero-latency array model so the pipeline can be run against a memory with real, multi-cycle latency.

Parameters:
- MEM_BYTES, 1024, RAM depth in bytes; must be a power of two and at least 8.
- ADDR_W, 10, internal RAM index width; equals log2(MEM_BYTES).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = write (rmmovq/pushq/call), 0 = read (mrmovq/popq/ret).
- req_addr_i  in  64  byte address of the least-significant byte.
- req_wdata_i  in  64  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer accepts the response.
- rsp_rdata_o  out  64  read data; 0 for writes and for errors.
- rsp_error_o  out  1  dmem error; qualified by rsp_valid_o.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_n_i is asynchronous and active-low.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, byte counter=0. The RAM contents are never reset.
- States:
  - IDLE -> ACCESS on req_valid_i && req_ready_o when the address is in range.
  - IDLE -> RESP directly when the address is out of range; rsp_error_o=1 and no RAM access is made.
  - ACCESS -> RESP after 8 byte cycles.
  - RESP -> IDLE on rsp_ready_i.
- Handshake:
  - req_ready_o=1 only in IDLE.
  - Address, we and wdata are captured on the accept edge; the inputs may change afterwards.
  - rsp_valid_o stays high with stable data until rsp_ready_i=1.
  - rsp_ready_i is ignored outside RESP.
- Range check: error when req_addr_i > MEM_BYTES-8, compared on the full 64 bits with no addition, so addresses near 2^64 cannot wrap into range.
- ACCESS:
  - Counter k runs 0..7, one byte per cycle.
  - Write: RAM[addr+k] <= wdata[8k+7:8k].
  - Read: byte k is issued at cycle k and lands in rdata[8k+7:8k] one cycle later, since RAM read latency is 1.
  - The read path needs one extra drain cycle, so both reads and writes spend exactly 9 cycles in ACCESS, uniform for the bench.
- Latency, accept edge to rsp_valid_o high: 10 cycles for in-range requests, 1 cycle for errors.
- Back-to-back operation: a new request can be accepted the cycle after the response handshake; no request/response overlap.
- Reset mid-operation: the state returns to IDLE immediately and the response is dropped. Bytes already written stay written; partial writes are not rolled back.
- Hierarchy: the RAM instance is named "ram" and its array "mem" so the bench can backdoor preload and check it.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: req_addr_i[2:0] != 0 is also an error and takes the 1-cycle error path; rsp_rdata_o=0 and RAM is untouched.
- Undefined: unaligned addresses are served byte-wise like any other in-range address.

Decomposition:
- Shared definitions, added next to the existing icode constants:
  - State encodings `DMEM_IDLE=2'd0`, `DMEM_ACCESS=2'd1`, `DMEM_RESP=2'd2`.
  - `DMEM_WORD_BYTES=8`.
- Sub-module dmem_byte_ram:
  - Single-port, byte-wide synchronous RAM with MEM_BYTES depth.
  - Ports: we, addr[ADDR_W-1:0], wdata[7:0], rdata[7:0] with registered read.
  - Array named mem.
- dmem_responder holds the FSM, counter, range and alignment check, and data assembly.

Test Plan:
- Preload mem[i]=i[7:0]; read addr 0x0E -> after 10 cycles rsp_valid=1, rdata=0x1514131211100F0E, error=0.
- Write addr 0x0E, wdata=0x000000000000000A, then read 0x0E -> rdata=0x000000000000000A; mem[0x0E]=0x0A, mem[0x0F..0x15]=0x00, mem[0x16]=0x16 unchanged.
- Read addr 1016 -> ok, rdata=0xFFFEFDFCFBFAF9F8. Read addr 1017 -> rsp_valid 1 cycle after accept, error=1, rdata=0. Write addr 0xFFFFFFFFFFFFFFFC -> error=1, no RAM change.
- Hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready_o=0; a new req_valid_i during that time is not accepted until the cycle after the response handshake.
- Deassert rst_n_i at ACCESS byte 3 of a write of 0x1122334455667788 to addr 0x20 -> outputs return to reset values asynchronously; mem[0x20..0x23]=88,77,66,55 and mem[0x24..0x27] are unchanged.
- With DMEM_ALIGN_CHECK_EN: read addr 0x0A -> error=1 in 1 cycle. Without it: rdata=0x11100F0E0D0C0B0A.
